// File: rtl/mul_sched_pkg.sv
// Shared constants and helpers for the multiplier scheduler.
// Holds the FSM encoding, default sizes and small pure functions.
package mul_sched_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 64;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    function automatic int clog2(input int value);
        int v;
        int w;
        v = value - 32'sd1;
        w = 32'sd0;
        while (v > 32'sd0) begin
            w = w + 32'sd1;
            v = v >>> 1;
        end
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mul_scheduler_rr_arb2.sv
// Two-way round-robin arbiter for the multiplier scheduler.
// The pointer names the requester that wins a tie; it moves away from the last owner.
module rr_arb2
    import mul_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       owner,
    output logic [1:0] gnt
);

    logic ptr_r;

    // One-hot winner from the request levels and the tie-break pointer.
    always_comb begin
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = onehot2(ptr_r);
            default: gnt = 2'b00;
        endcase
    end

    // Pointer update: the owner just served drops to lowest priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= 1'b0;
        end else if (upd) begin
            ptr_r <= ~owner;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// Sequencer/arbiter in front of the shared shift-add multiplier core.
// Grants one requester, starts the core, waits for done or a watchdog abort, returns the product.
module mul_scheduler
    import mul_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic [1:0]           ack,
    output logic [1:0]           vld,
    output logic [2*WIDTH-1:0]   res,
    output logic                 err,
    output logic                 mul_st,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_p
);

    localparam int WD_W = clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    logic [1:0]         state_r;
    logic [1:0]         state_s;
    logic               owner_r;
    logic               owner_s;
    logic [WD_W-1:0]    wd_r;
    logic [1:0]         gnt_s;
    logic               err_s;
    logic [1:0]         ack_r;
    logic [1:0]         vld_r;
    logic               err_r;
    logic               mul_st_r;
    logic [WIDTH-1:0]   mul_a_r;
    logic [WIDTH-1:0]   mul_b_r;
    logic [2*WIDTH-1:0] res_r;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .upd   (state_r == S_RESP),
        .owner (owner_r),
        .gnt   (gnt_s)
    );

    // Next-state decode; mul_done only matters while waiting on the core.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        err_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (gnt_s != 2'b00) begin
                    state_s = S_START;
                    owner_s = gnt_s[1];
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: state_s = S_WAIT;
            S_WAIT: begin
                if (mul_done) begin
                    state_s = S_RESP;
                end else if (wd_r == WD_MAX) begin
                    state_s = S_RESP;
                    err_s   = 1'b1;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RESP:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state and job owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            owner_r <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
        end
    end

    // Operands are captured at grant and held until the next grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a_r <= {WIDTH{1'b0}};
            mul_b_r <= {WIDTH{1'b0}};
        end else if (state_r == S_IDLE && gnt_s != 2'b00) begin
            mul_a_r <= gnt_s[1] ? a1 : a0;
            mul_b_r <= gnt_s[1] ? b1 : b0;
        end else begin
            mul_a_r <= mul_a_r;
            mul_b_r <= mul_b_r;
        end
    end

    // Watchdog: cleared at start, counts WAIT cycles, stops at the abort point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_r <= {WD_W{1'b0}};
        end else if (state_r == S_START) begin
            wd_r <= {WD_W{1'b0}};
        end else if (state_r == S_WAIT && state_s == S_WAIT) begin
            wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wd_r <= wd_r;
        end
    end

    // Result capture; an aborted job reports a zero product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_r <= {(2*WIDTH){1'b0}};
        end else if (state_r == S_WAIT && mul_done) begin
            res_r <= mul_p;
        end else if (state_r == S_WAIT && err_s) begin
            res_r <= {(2*WIDTH){1'b0}};
        end else begin
            res_r <= res_r;
        end
    end

    // Strobes registered from the next state so they line up with START/RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_r    <= 2'b00;
            vld_r    <= 2'b00;
            err_r    <= 1'b0;
            mul_st_r <= 1'b0;
        end else begin
            ack_r    <= (state_s == S_START) ? onehot2(owner_s) : 2'b00;
            vld_r    <= (state_s == S_RESP)  ? onehot2(owner_s) : 2'b00;
            err_r    <= err_s;
            mul_st_r <= (state_s == S_START);
        end
    end

    assign ack    = ack_r;
    assign vld    = vld_r;
    assign err    = err_r;
    assign mul_st = mul_st_r;
    assign mul_a  = mul_a_r;
    assign mul_b  = mul_b_r;
    assign res    = res_r;

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with a behavioural multiplier core and output monitor.
module tb_mul_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [7:0]  a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
    logic [1:0]  ack, vld;
    logic [15:0] res;
    logic        err, mul_st;
    logic [7:0]  mul_a, mul_b;
    logic        mul_done;
    logic [15:0] mul_p;

    logic        core_done;
    logic        spur_done = 1'b0;
    logic [15:0] core_p;
    bit          core_en = 1'b1;
    int          core_delay = 10;
    int          core_cnt;
    bit          core_busy;

    int vectors = 0;
    int errors  = 0;

    logic [1:0]  ack_q[$];
    logic [1:0]  vld_q[$];
    int          ack_cyc_q[$];
    int          vld_cyc_q[$];
    logic [7:0]  acka_q[$];
    logic [7:0]  ackb_q[$];
    logic [15:0] vres_q[$];
    logic        verr_q[$];
    int          cyc = 0;
    int          st_mis = 0;
    int          onehot_bad = 0;
    int          err_stray = 0;

    mul_scheduler #(.WIDTH(8), .TIMEOUT(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .ack      (ack),
        .vld      (vld),
        .res      (res),
        .err      (err),
        .mul_st   (mul_st),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_done (mul_done),
        .mul_p    (mul_p)
    );

    always #5 clk = ~clk;

    assign mul_done = core_done | spur_done;
    assign mul_p    = core_p;

    // Behavioural core: raises done for one cycle core_delay edges after seeing start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_done <= 1'b0;
            core_p    <= 16'd0;
            core_cnt  <= 0;
            core_busy <= 1'b0;
        end else begin
            core_done <= 1'b0;
            if (mul_st && core_en) begin
                core_busy <= 1'b1;
                core_cnt  <= 1;
            end else if (core_busy) begin
                if (core_cnt == core_delay) begin
                    core_done <= 1'b1;
                    core_p    <= 16'(mul_a) * 16'(mul_b);
                    core_busy <= 1'b0;
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end
        end
    end

    // Monitor: logs every ack/vld pulse with its cycle and flags protocol oddities.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ack !== 2'b00) begin
            ack_q.push_back(ack);
            ack_cyc_q.push_back(cyc);
            acka_q.push_back(mul_a);
            ackb_q.push_back(mul_b);
        end
        if (vld !== 2'b00) begin
            vld_q.push_back(vld);
            vld_cyc_q.push_back(cyc);
            vres_q.push_back(res);
            verr_q.push_back(err);
        end
        if ((ack != 2'b00) !== mul_st) st_mis <= st_mis + 1;
        if (ack == 2'b11 || vld == 2'b11) onehot_bad <= onehot_bad + 1;
        if (err && vld == 2'b00) err_stray <= err_stray + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ack_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (ack_q.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_vld(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (vld_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (vld_q.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        tick(2);
        vectors++;
        if ({ack, vld, err, mul_st} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000000", {ack, vld, err, mul_st});
        end
        vectors++;
        if ({mul_a, mul_b, res} !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {mul_a, mul_b, res});
        end
        rst = 1'b1;
        tick(3);
        vectors++;
        if (ack_q.size() !== 0 || vld_q.size() !== 0) begin
            errors++;
            $display("FAIL idle_quiet: got acks=%0d vlds=%0d want 0/0", ack_q.size(), vld_q.size());
        end
    endtask

    task automatic test_single();
        int ba, bv;
        bit ok;
        ba = ack_q.size();
        bv = vld_q.size();
        a0 = 8'd13; b0 = 8'd11; core_delay = 10;
        req = 2'b01;
        wait_ack(ba + 1, 10, ok);
        req = 2'b00;
        vectors++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL single_ack_timeout: got no ack want ack");
        end else begin
            vectors++;
            if ({ack_q[ba], acka_q[ba], ackb_q[ba]} !== {2'b01, 8'd13, 8'd11}) begin
                errors++;
                $display("FAIL single_ack: got %b a=%0d b=%0d want 01 a=13 b=11", ack_q[ba], acka_q[ba], ackb_q[ba]);
            end
        end
        tick(4);
        vectors++;
        if ({mul_a, mul_b} !== {8'd13, 8'd11}) begin
            errors++;
            $display("FAIL single_hold: got a=%0d b=%0d want 13/11", mul_a, mul_b);
        end
        wait_vld(bv + 1, 40, ok);
        vectors++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL single_vld_timeout: got no vld want vld");
        end else begin
            vectors++;
            if ({vld_q[bv], vres_q[bv], verr_q[bv]} !== {2'b01, 16'd143, 1'b0}) begin
                errors++;
                $display("FAIL single_res: got vld=%b res=%0d err=%b want 01/143/0", vld_q[bv], vres_q[bv], verr_q[bv]);
            end
        end
        tick(6);
        vectors++;
        if (ack_q.size() !== ba + 1 || vld_q.size() !== bv + 1) begin
            errors++;
            $display("FAIL single_count: got acks=%0d vlds=%0d want %0d/%0d", ack_q.size(), vld_q.size(), ba + 1, bv + 1);
        end
        vectors++;
        if (res !== 16'd143) begin
            errors++;
            $display("FAIL single_res_hold: got %0d want 143", res);
        end
    endtask

    task automatic test_reset_mid();
        int ba, bv;
        bit ok;
        ba = ack_q.size();
        bv = vld_q.size();
        a1 = 8'd9; b1 = 8'd9; core_delay = 30;
        req = 2'b10;
        wait_ack(ba + 1, 10, ok);
        req = 2'b00;
        tick(5);
        rst = 1'b0;
        #1;
        vectors++;
        if ({ack, vld, err, mul_st, mul_a, mul_b, res} !== 38'd0) begin
            errors++;
            $display("FAIL midreset_outs: got %h want 0", {ack, vld, err, mul_st, mul_a, mul_b, res});
        end
        tick(3);
        vectors++;
        if (vld_q.size() !== bv) begin
            errors++;
            $display("FAIL midreset_novld: got vlds=%0d want %0d", vld_q.size(), bv);
        end
        a0 = 8'd1; b0 = 8'd2; a1 = 8'd3; b1 = 8'd4; core_delay = 3;
        req = 2'b11;
        rst = 1'b1;
        wait_ack(ba + 2, 10, ok);
        req = 2'b10;
        vectors++;
        if (ok !== 1'b1 || ack_q.size() < ba + 2) begin
            errors++;
            $display("FAIL midreset_ack_timeout: got no ack want ack");
        end else begin
            vectors++;
            if (ack_q[ba + 1] !== 2'b01) begin
                errors++;
                $display("FAIL midreset_ptr: got %b want 01", ack_q[ba + 1]);
            end
        end
        wait_ack(ba + 3, 30, ok);
        req = 2'b00;
        wait_vld(bv + 2, 30, ok);
        vectors++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL midreset_vld_timeout: got %0d vlds want %0d", vld_q.size(), bv + 2);
        end else begin
            vectors++;
            if ({vld_q[bv], vres_q[bv], vld_q[bv + 1], vres_q[bv + 1]} !== {2'b01, 16'd2, 2'b10, 16'd12}) begin
                errors++;
                $display("FAIL midreset_jobs: got %b/%0d %b/%0d want 01/2 10/12", vld_q[bv], vres_q[bv], vld_q[bv + 1], vres_q[bv + 1]);
            end
        end
    endtask

    task automatic test_contention();
        int ba, bv;
        bit ok;
        logic [1:0]  exp_owner [4];
        logic [15:0] exp_res [4];
        exp_owner = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_res   = '{16'd15, 16'd63, 16'd15, 16'd63};
        ba = ack_q.size();
        bv = vld_q.size();
        a0 = 8'd3; b0 = 8'd5; a1 = 8'd7; b1 = 8'd9; core_delay = 2;
        req = 2'b11;
        wait_ack(ba + 3, 60, ok);
        req = 2'b00;
        wait_vld(bv + 3, 30, ok);
        tick(3);
        req = 2'b11;
        wait_ack(ba + 4, 20, ok);
        req = 2'b00;
        wait_vld(bv + 4, 30, ok);
        tick(6);
        vectors++;
        if (ack_q.size() !== ba + 4 || vld_q.size() !== bv + 4) begin
            errors++;
            $display("FAIL contention_count: got acks=%0d vlds=%0d want %0d/%0d", ack_q.size() - ba, vld_q.size() - bv, 4, 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if ({ack_q[ba + i], vld_q[bv + i], vres_q[bv + i]} !== {exp_owner[i], exp_owner[i], exp_res[i]}) begin
                    errors++;
                    $display("FAIL contention_job%0d: got ack=%b vld=%b res=%0d want %b/%b/%0d", i, ack_q[ba + i], vld_q[bv + i], vres_q[bv + i], exp_owner[i], exp_owner[i], exp_res[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (ack_cyc_q[ba + i] - ack_cyc_q[ba + i - 1] < 4) begin
                    errors++;
                    $display("FAIL contention_gap%0d: got %0d cycles want >=4", i, ack_cyc_q[ba + i] - ack_cyc_q[ba + i - 1]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int ba, bv;
        bit ok;
        ba = ack_q.size();
        bv = vld_q.size();
        core_en = 1'b0;
        a0 = 8'd2; b0 = 8'd3;
        req = 2'b01;
        wait_ack(ba + 1, 10, ok);
        req = 2'b00;
        wait_vld(bv + 1, 100, ok);
        vectors++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL timeout_vld: got no vld want vld");
        end else begin
            vectors++;
            if ({vld_q[bv], vres_q[bv], verr_q[bv]} !== {2'b01, 16'd0, 1'b1}) begin
                errors++;
                $display("FAIL timeout_res: got vld=%b res=%0d err=%b want 01/0/1", vld_q[bv], vres_q[bv], verr_q[bv]);
            end
            vectors++;
            if (vld_cyc_q[bv] - (ack_cyc_q[ba] + 1) !== 64) begin
                errors++;
                $display("FAIL timeout_latency: got %0d want 64", vld_cyc_q[bv] - (ack_cyc_q[ba] + 1));
            end
        end
        core_en = 1'b1;
        core_delay = 4;
        a1 = 8'd4; b1 = 8'd6;
        req = 2'b10;
        wait_ack(ba + 2, 10, ok);
        req = 2'b00;
        wait_vld(bv + 2, 30, ok);
        vectors++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL after_timeout_vld: got no vld want vld");
        end else begin
            vectors++;
            if ({vld_q[bv + 1], vres_q[bv + 1], verr_q[bv + 1]} !== {2'b10, 16'd24, 1'b0}) begin
                errors++;
                $display("FAIL after_timeout_res: got vld=%b res=%0d err=%b want 10/24/0", vld_q[bv + 1], vres_q[bv + 1], verr_q[bv + 1]);
            end
        end
    endtask

    task automatic test_spurious();
        int ba, bv;
        bit ok;
        ba = ack_q.size();
        bv = vld_q.size();
        tick(2);
        spur_done = 1'b1;
        tick(1);
        spur_done = 1'b0;
        tick(3);
        vectors++;
        if (vld_q.size() !== bv) begin
            errors++;
            $display("FAIL spur_idle: got vlds=%0d want %0d", vld_q.size(), bv);
        end
        a0 = 8'd255; b0 = 8'd255; core_delay = 5;
        req = 2'b01;
        wait_ack(ba + 1, 10, ok);
        req = 2'b00;
        spur_done = 1'b1;
        tick(1);
        spur_done = 1'b0;
        wait_vld(bv + 1, 30, ok);
        tick(4);
        vectors++;
        if (vld_q.size() !== bv + 1) begin
            errors++;
            $display("FAIL spur_start_count: got vlds=%0d want %0d", vld_q.size(), bv + 1);
        end else begin
            vectors++;
            if ({vld_q[bv], vres_q[bv], verr_q[bv]} !== {2'b01, 16'd65025, 1'b0}) begin
                errors++;
                $display("FAIL max_operands: got vld=%b res=%0d err=%b want 01/65025/0", vld_q[bv], vres_q[bv], verr_q[bv]);
            end
        end
        a1 = 8'd0; b1 = 8'd200;
        req = 2'b10;
        wait_ack(ba + 2, 10, ok);
        req = 2'b00;
        wait_vld(bv + 2, 30, ok);
        vectors++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL zero_operand_vld: got no vld want vld");
        end else begin
            vectors++;
            if ({vld_q[bv + 1], vres_q[bv + 1], verr_q[bv + 1]} !== {2'b10, 16'd0, 1'b0}) begin
                errors++;
                $display("FAIL zero_operand: got vld=%b res=%0d err=%b want 10/0/0", vld_q[bv + 1], vres_q[bv + 1], verr_q[bv + 1]);
            end
        end
    endtask

    task automatic test_protocol();
        tick(2);
        vectors++;
        if (st_mis !== 0) begin
            errors++;
            $display("FAIL start_ack_align: got %0d mismatched cycles want 0", st_mis);
        end
        vectors++;
        if (onehot_bad !== 0) begin
            errors++;
            $display("FAIL onehot: got %0d double pulses want 0", onehot_bad);
        end
        vectors++;
        if (err_stray !== 0) begin
            errors++;
            $display("FAIL err_without_vld: got %0d cycles want 0", err_stray);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_contention();
        test_timeout();
        test_spurious();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish by 100000 want finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/mul_scheduler.md
# mul_scheduler

Sequencer and arbiter for the shared shift-add multiplier. Two requesters (e.g. the ALU path and the MULT/MULTU issue path) compete for one multiplier core. The block grants one requester at a time, latches its operands, and pulses the core's start input. It then waits for the core's done flag, captures the product, and returns it with a one-cycle valid. A watchdog aborts a job if the core never signals done.

## Interface
Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH.
- TIMEOUT, 64, maximum number of WAIT cycles before abort; must be ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (low = reset).
- req  in  2  per-requester request level; held high until the matching ack.
- a0, b0  in  WIDTH each  requester 0 operands; stable while req[0] is high.
- a1, b1  in  WIDTH each  requester 1 operands; stable while req[1] is high.
- ack  out  2  one-hot, one-cycle grant/operands-taken pulse.
- vld  out  2  one-hot, one-cycle result-valid pulse to the owner.
- res  out  2*WIDTH  product; held from capture until the next capture.
- err  out  1  high with vld when the job timed out.
- mul_st  out  1  start pulse to the multiplier core.
- mul_a, mul_b  out  WIDTH each  operands to the core; held for the whole job.
- mul_done  in  1  core completion flag.
- mul_p  in  2*WIDTH  core product, valid while mul_done is high.

## Operation
- **Reset values:** state IDLE, priority pointer = 0, ack = 0, vld = 0, err = 0, mul_st = 0, mul_a = mul_b = 0, res = 0, watchdog = 0.
- **FSM** (state register; all outputs except res/mul_a/mul_b are decoded from state):
  - **IDLE:** no request → stay. Otherwise pick the owner.
    - Only one req high → that requester.
    - Both high → the requester indicated by the pointer.
    - Latch that requester's a/b into mul_a/mul_b and store the owner; → START.
  - **START:** mul_st = 1; ack[owner] = 1; clear watchdog; → WAIT.
  - **WAIT:**
    - mul_done = 1 → res ← mul_p, err ← 0, → RESP.
    - Else, watchdog == TIMEOUT-1 → res ← 0, err ← 1, → RESP.
    - Else watchdog++.
  - **RESP:** vld[owner] = 1; err is driven. Pointer ← owner ^ 1 (last winner gets lowest priority). → IDLE.
- mul_done is ignored in IDLE, START and RESP.
- req falling after ack has no effect. req falling before grant simply withdraws the request.
- Arbitration happens only in IDLE. A request held across RESP is considered in the following IDLE cycle.
- Watchdog width is clog2(TIMEOUT); it never wraps.
- **Reset mid-job:** everything returns immediately to the reset values. The job is lost and no vld is issued. The core is expected to be reset by the same rst.

## Timing
- req seen at edge E0 in IDLE → ack and mul_st high in cycle E0–E1 → WAIT from E1.
- mul_done sampled high at edge Ek → res is updated at Ek, and vld is high in cycle Ek–Ek+1 → IDLE at Ek+1.
- Minimum spacing: 4 cycles from one ack to the next (IDLE, START, WAIT≥1, RESP).
- A timeout raises vld/err TIMEOUT cycles after entering WAIT.
- No combinational path from req, a or b to any output. mul_done affects only registered state.

## Structure
- Package mul_sched_pkg holds:
  - the state encoding (IDLE=0, START=1, WAIT=2, RESP=3);
  - the default WIDTH and TIMEOUT constants;
  - a clog2 helper for the watchdog width.
- Sub-module rr_arb2 holds:
  - the priority pointer;
  - the two-way round-robin pick (req, pointer → one-hot winner);
  - the pointer update on RESP.
- The top level holds the FSM, operand/result registers and watchdog.

## Test plan
- **Reset mid-WAIT:** drive rst low → all outputs 0 on the same cycle. Then assert req = 2'b11 → ack = 2'b01 (pointer reset to 0).
- **Single job:** req[0] with a0 = 13, b0 = 11; behavioural core asserts mul_done 10 cycles after mul_st with mul_p = 143.
  - Expect one ack[0] pulse coincident with mul_st, and mul_a = 13, mul_b = 11.
  - Then exactly one vld[0] cycle with res = 143 and err = 0.
- **Contention:** req = 2'b11 held → order of service is 0, then 1. Re-raise both → 1 is served first. Check the pointer alternates and there is no double ack.
- **Timeout:** core never asserts done with TIMEOUT = 64 → vld[owner] exactly 64 cycles after WAIT entry, with err = 1 and res = 0. The next job completes normally with err = 0.
- **Spurious done / extremes:** pulse mul_done in IDLE and START → no vld. Then run operands 255 × 255 → res = 65025. Also run 0 × 200 → res = 0.
